// File: rtl/ahfp_normalize.sv
// ahfp_normalize
// Normalise-round-pack stage for the floating-point datapath. It takes an
// unnormalised 48-bit magnitude, a sign and a signed working exponent, and
// returns a packed binary32 result with exception flags. Rounding is
// round-to-nearest-even only. Denormals are flushed to signed zero.
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   in_valid     input beat present
//   in_ready     block accepts a beat this cycle
//   in_sign      result sign
//   in_exp       10-bit two's-complement biased exponent;
//                value = 2^(in_exp-127) * in_mant / 2^46
//   in_mant      unsigned magnitude, binary point between bits 46 and 45
//   out_valid    result present
//   out_ready    downstream accepts the result
//   out_result   packed binary32
//   out_flags    {inexact, underflow, overflow, zero}
//
// Pipeline: detect (register input + leading-zero count), shift (normalised
// mantissa + adjusted exponent), round/pack (output registers).
//
// Handshake: a beat moves on a rising edge where valid & ready are both high
// on that interface. All three stages advance together when
// adv = ~out_valid | out_ready. in_ready is exactly adv, so it never depends
// on in_valid. While out_valid & ~out_ready every stage freezes and the
// outputs hold. Empty stages are not collapsed.

module ahfp_normalize (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  // Leading-zero count, 48 when the operand is zero.
  function automatic logic [5:0] count_lz(input logic [47:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd48;
    found = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(47 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic adv;

  // Stage 1: registered input and its leading-zero count.
  logic        v1;
  logic        s1_sign;
  logic [9:0]  s1_exp;
  logic [47:0] s1_mant;
  logic [5:0]  s1_lz;

  // Stage 2: normalised mantissa and adjusted exponent.
  logic        v2;
  logic        s2_sign;
  logic        s2_zero;
  logic [47:0] s2_m;
  logic [10:0] s2_e;     // two's complement, wide enough that no value wraps

  // Round/pack combinational results.
  logic [22:0] frac;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] frac_sum;
  logic [10:0] e_rnd;
  logic [31:0] pack_result;
  logic [3:0]  pack_flags;
  logic [10:0] s1_e_next;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // exp + 1 - lz, sign-extended to 11 bits so that even -512 - 47 stays exact.
  assign s1_e_next = {s1_exp[9], s1_exp} + 11'd1 - {5'd0, s1_lz};

  // Valid bits and output registers are the only reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= 32'h0;
      out_flags  <= 4'h0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        out_result <= pack_result;
        out_flags  <= pack_flags;
      end
    end
  end

  // Data path registers carry no reset; their contents only matter under a
  // set valid bit.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= in_sign;
      s1_exp  <= in_exp;
      s1_mant <= in_mant;
      s1_lz   <= count_lz(in_mant);

      s2_sign <= s1_sign;
      s2_zero <= (s1_mant == 48'd0);
      s2_m    <= s1_mant << s1_lz;
      s2_e    <= s1_e_next;
    end
  end

  // Round to nearest even on the 24-bit significand (hidden one at m[47]).
  always_comb begin
    frac     = s2_m[46:24];
    guard    = s2_m[23];
    sticky   = |s2_m[22:0];
    round_up = guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + {23'd0, round_up};
    // A carry out of the fraction means the significand became 10.000...;
    // the stored fraction bits are already zero, only the exponent moves.
    e_rnd    = s2_e + {10'd0, frac_sum[23]};
  end

  // Output case selection in priority order: zero, overflow, underflow, normal.
  always_comb begin
    pack_result = {s2_sign, 31'd0};
    pack_flags  = 4'b0000;
    if (s2_zero) begin
      pack_result = {s2_sign, 31'd0};
      pack_flags  = 4'b0001;
    end else if ($signed(e_rnd) >= 11'sd255) begin
      pack_result = {s2_sign, 8'hFF, 23'd0};
      pack_flags  = 4'b1010;
    end else if ($signed(e_rnd) <= 11'sd0) begin
      pack_result = {s2_sign, 31'd0};
      pack_flags  = 4'b1101;
    end else begin
      pack_result = {s2_sign, e_rnd[7:0], frac_sum[22:0]};
      pack_flags  = {guard | sticky, 3'b000};
    end
  end

endmodule

// File: tb/tb_ahfp_normalize.sv
// Self-checking bench for ahfp_normalize: directed vector table, latency,
// randomised back-pressure stream against a value-level reference model,
// and reset in the middle of a stream.

module tb_ahfp_normalize;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  ahfp_normalize dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard state ----------------
  logic [35:0] exp_q[$];   // {result, flags}
  bit   bp_mode    = 1'b0;
  int   accept_edge = 0;
  int   xfer_edge   = 0;
  int   xfer_count  = 0;
  int   sent_count  = 0;
  int   dropped     = 0;

  typedef struct {
    bit          sign;
    logic [9:0]  exp;
    logic [47:0] mant;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[16];

  // ---------------- reference model ----------------
  // Works on the numeric value: find the weight of the leading one, keep 24
  // significant bits, compare the discarded remainder against one half ulp.
  function automatic logic [35:0] ref_model(input bit s, input logic [9:0] e,
                                            input logic [47:0] m);
    int          p;
    int          be;
    int          sh;
    logic [63:0] q;
    logic [63:0] rem;
    logic [63:0] half;
    bit          inexact;
    if (m == 48'd0) return {s, 31'd0, 4'b0001};
    p = 0;
    for (int i = 0; i < 48; i++) if (m[i]) p = i;
    be = int'($signed(e)) + p - 46;
    sh = p - 23;
    inexact = 1'b0;
    if (sh > 0) begin
      q    = 64'(m) >> sh;
      rem  = 64'(m) & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inexact = (rem != 64'd0);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    end else begin
      q = 64'(m) << (-sh);
    end
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      be = be + 1;
    end
    if (be >= 255) return {s, 8'hFF, 23'd0, 4'b1010};
    if (be <= 0)   return {s, 31'd0, 4'b1101};
    return {s, 8'(be), q[22:0], inexact, 3'b000};
  endfunction

  // ---------------- monitor ----------------
  bit          prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [3:0]  prev_flags;

  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        checks++;
        if (in_ready !== !(out_valid && !out_ready)) begin
          errors++;
          $display("FAIL in_ready got %b want %b (out_valid %b out_ready %b) cyc %0d",
                   in_ready, !(out_valid && !out_ready), out_valid, out_ready, cyc);
        end
        if (prev_stall) begin
          checks++;
          if (out_valid !== 1'b1 || out_result !== prev_res || out_flags !== prev_flags) begin
            errors++;
            $display("FAIL stall_hold got v%b %h/%b want v1 %h/%b cyc %0d",
                     out_valid, out_result, out_flags, prev_res, prev_flags, cyc);
          end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          checks++;
          xfer_edge = cyc + 1;
          xfer_count++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got %h/%b want none cyc %0d",
                     out_result, out_flags, cyc);
          end else begin
            e = exp_q.pop_front();
            if ({out_result, out_flags} !== e) begin
              errors++;
              $display("FAIL beat %0d got %h/%b want %h/%b", xfer_count,
                       out_result, out_flags, e[35:4], e[3:0]);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = out_result;
        prev_flags = out_flags;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input bit v, input bit s, input logic [9:0] e,
                             input logic [47:0] m, output bit accepted);
    @(negedge clk);
    in_valid  = v;
    in_sign   = s;
    in_exp    = e;
    in_mant   = m;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    accepted = v && in_ready;
    if (accepted) accept_edge = cyc + 1;
  endtask

  task automatic send(input bit s, input logic [9:0] e, input logic [47:0] m,
                      input logic [35:0] expected);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 1000) begin
      drive_cycle(1'b1, s, e, m, acc);
      tries++;
    end
    if (acc) begin
      exp_q.push_back(expected);
      sent_count++;
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready 0 want 1 within 1000 cycles");
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 10'd0, 48'd0, acc);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      idle(1);
      budget++;
    end
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [47:0] m;
    logic [9:0]  e;
    bit          s;
    int          a;

    vecs[0]  = '{1'b0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 4'b0000};
    vecs[1]  = '{1'b0, 10'd127, 48'h8000_0000_0000, 32'h4000_0000, 4'b0000};
    vecs[2]  = '{1'b0, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 4'b1000};
    vecs[3]  = '{1'b0, 10'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 4'b1000};
    vecs[4]  = '{1'b0, 10'd127, 48'h7FFF_FFC0_0000, 32'h4000_0000, 4'b1000};
    vecs[5]  = '{1'b0, 10'd254, 48'h8000_0000_0000, 32'h7F80_0000, 4'b1010};
    vecs[6]  = '{1'b0, 10'd0,   48'h4000_0000_0000, 32'h0000_0000, 4'b1101};
    vecs[7]  = '{1'b1, 10'd127, 48'h0000_0000_0000, 32'h8000_0000, 4'b0001};
    vecs[8]  = '{1'b1, 10'd127, 48'h4000_0000_0000, 32'hBF80_0000, 4'b0000};
    vecs[9]  = '{1'b0, 10'd127, 48'h0000_0000_0001, 32'h2880_0000, 4'b0000};
    vecs[10] = '{1'b0, 10'd1,   48'h4000_0000_0000, 32'h0080_0000, 4'b0000};
    vecs[11] = '{1'b0, 10'd253, 48'hFFFF_FFFF_FFFF, 32'h7F80_0000, 4'b1010};
    vecs[12] = '{1'b0, 10'h3FF, 48'h8000_0000_0000, 32'h0000_0000, 4'b1101};
    vecs[13] = '{1'b0, 10'd127, 48'h4000_0020_0000, 32'h3F80_0000, 4'b1000};
    vecs[14] = '{1'b1, 10'd200, 48'h8000_0000_0001, 32'hE480_0000, 4'b1000};
    vecs[15] = '{1'b0, 10'd300, 48'h4000_0000_0000, 32'h7F80_0000, 4'b1010};

    // Reset state, with out_ready low to show in_ready is still 1.
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 10'd0;
    in_mant   = 48'd0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 4'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v%b %h/%b rdy%b want v0 00000000/0000 rdy1",
               out_valid, out_result, out_flags, in_ready);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed table at full rate.
    bp_mode = 1'b0;
    foreach (vecs[i]) send(vecs[i].sign, vecs[i].exp, vecs[i].mant, {vecs[i].res, vecs[i].flags});
    drain();

    // Latency through an empty pipeline.
    send(vecs[0].sign, vecs[0].exp, vecs[0].mant, {vecs[0].res, vecs[0].flags});
    a = accept_edge;
    drain();
    checks++;
    if (xfer_edge - a != 3) begin
      errors++;
      $display("FAIL latency got %0d want 3", xfer_edge - a);
    end

    // Back-pressure: six directed beats back to back, then a random stream.
    bp_mode = 1'b1;
    for (int i = 0; i < 6; i++)
      send(vecs[i].sign, vecs[i].exp, vecs[i].mant, {vecs[i].res, vecs[i].flags});
    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom_range(0, 1));
      m = {16'($urandom), 32'($urandom)} >> $urandom_range(0, 48);
      if ($urandom_range(0, 3) == 0) m = m & (48'hFFFF_FFFF_FFFF << $urandom_range(18, 30));
      case ($urandom_range(0, 3))
        0: e = 10'($urandom);
        1: e = 10'($urandom_range(0, 70));
        2: e = 10'($urandom_range(220, 290));
        default: e = 10'($urandom_range(100, 160));
      endcase
      send(s, e, m, ref_model(s, e, m));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    drain();

    // Reset with three beats in flight.
    bp_mode = 1'b0;
    for (int i = 0; i < 3; i++)
      send(vecs[i].sign, vecs[i].exp, vecs[i].mant, {vecs[i].res, vecs[i].flags});
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #5;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid got %b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 4'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got v%b %h/%b rdy%b want v0 00000000/0000 rdy1",
               out_valid, out_result, out_flags, in_ready);
    end
    dropped += exp_q.size();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(8);
    send(vecs[8].sign, vecs[8].exp, vecs[8].mant, {vecs[8].res, vecs[8].flags});
    a = accept_edge;
    drain();
    checks++;
    if (xfer_edge - a != 3) begin
      errors++;
      $display("FAIL post_reset_latency got %0d want 3", xfer_edge - a);
    end

    // Every accepted beat that was not discarded by reset came out exactly once.
    checks++;
    if (xfer_count != sent_count - dropped) begin
      errors++;
      $display("FAIL beat_count got %0d want %0d", xfer_count, sent_count - dropped);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
